note2dds_voice_sched: RTL and testbench
=======================================

// Module: note2dds_voice_sched
// PURPOSE
//  Time-multiplexes one note-to-DDS-increment converter across NUM_VOICES synth voices.
//  Voices post update requests. A round-robin scheduler issues each voice's MIDI note to
//  the converter, waits the converter latency, then latches the returned 32-bit phase
//  increment into that voice's ADDER register. Sits between the voice/MIDI logic and the
//  per-voice DDS phase accumulators.
// PARAMETERS
//  NUM_VOICES  4  number of voices sharing the converter (2..16)
//  CONV_LAT    1  cycles from CONV_NOTE change to CONV_ADDER valid (1..7)
// PORTS
//  CLK         in   1              system clock, all logic on posedge
//  RESET       in   1              asynchronous, active-high reset
//  REQ         in   NUM_VOICES     per-voice update request pulse (any width, level OK)
//  NOTES       in   7*NUM_VOICES   voice v note at NOTES[7v+6:7v], 0..127
//  CONV_NOTE   out  7              registered note driven to the shared converter
//  CONV_ADDER  in   32             increment returned by the converter
//  ADDER_OUT   out  32*NUM_VOICES  voice v increment at ADDER_OUT[32v+31:32v]
//  UPD         out  NUM_VOICES     1-cycle strobe, high in the cycle voice v's ADDER_OUT changes
//  BUSY        out  1              high while the FSM is not IDLE
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pending=0, rr_ptr=0, CONV_NOTE=0,
//   all ADDER_OUT=0, UPD=0, BUSY=0, wait counter=0.
//  Pending bits: pending[v] is set on any cycle REQ[v]=1. It is cleared at the issue edge
//   of voice v. If set and clear coincide for the same v, set wins, so v is served again.
//  FSM:
//   IDLE    if pending!=0: pick winner w = first set bit scanning rr_ptr, rr_ptr+1, ...
//           (mod NUM_VOICES). At the edge: CONV_NOTE<=NOTES[w], cur<=w, clear pending[w],
//           rr_ptr<=(w+1) mod NUM_VOICES, cnt<=CONV_LAT, go to WAIT. Else stay.
//   WAIT    cnt decrements each cycle. When cnt==1, go to CAPTURE (exactly CONV_LAT cycles).
//   CAPTURE at the edge: ADDER_OUT[cur]<=CONV_ADDER, UPD[cur]<=1, go to IDLE.
//  Timing, issue decision in cycle 0: CONV_NOTE is valid in cycle 1. WAIT spans cycles
//   1..CONV_LAT. CAPTURE is cycle CONV_LAT+1. New ADDER_OUT and UPD are seen in cycle
//   CONV_LAT+2, which is also an IDLE cycle that may issue the next voice.
//   Service period is CONV_LAT+2 cycles per voice.
//  NOTES is sampled only at the issue edge. Later changes need a new REQ.
//  CONV_NOTE holds the last issued value while idle.
//  UPD is one-hot or zero, and is deasserted the cycle after it pulses.
//  ADDER_OUT of unserved voices holds its value indefinitely.
//  BUSY=1 in WAIT and CAPTURE. It is 0 in IDLE, including the issue cycle 0.
//  No data transformation: the 32-bit capture is bit-exact.
//  Starvation bound: a pending voice is served within NUM_VOICES service periods.
//  RESET mid-service aborts the service. The voice is not updated, and its pending is lost.
// TESTING (NUM_VOICES=4, CONV_LAT=1, the team's note-to-DDS converter as CONV model)
//  1 Reset: assert RESET mid-WAIT -> BUSY, UPD, CONV_NOTE, all ADDER_OUT = 0 at once.
//    No UPD after release.
//  2 Single: NOTES[1]=69, REQ=4'b0010 one cycle (cycle 0) -> CONV_NOTE=69 in cycle 1.
//    ADDER_OUT[1]=18897 and UPD=4'b0010 in cycle 3.
//  3 Values: voices 0..2 with notes 0, 60, 127 -> ADDER_OUT = 351, 11236, 538754.
//  4 Contention: REQ=4'b1111 in cycle 0 -> UPD order 0,1,2,3 in cycles 3,6,9,12.
//  5 Round-robin: after serving voice 2, REQ 4'b0101 together -> voice 0 served before
//    voice 2. Repeat continuously -> no voice waits more than 4 periods.
//  6 Re-request: pulse REQ[3] on the issue edge of voice 3 -> voice 3 is served twice.
//    The second service uses the NOTES[3] value current at its own issue edge.

Source files
------------

// File: rtl/note2dds_voice_sched_if.sv
// Bundle between the voice logic, the shared note-to-DDS converter and the voice scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface note2dds_voice_sched_if #(
  parameter int NUM_VOICES = 4
) ();
  logic [NUM_VOICES-1:0]    REQ;
  logic [7*NUM_VOICES-1:0]  NOTES;
  logic [6:0]               CONV_NOTE;
  logic [31:0]              CONV_ADDER;
  logic [32*NUM_VOICES-1:0] ADDER_OUT;
  logic [NUM_VOICES-1:0]    UPD;
  logic                     BUSY;

  modport master (
    output REQ, NOTES, CONV_ADDER,
    input  CONV_NOTE, ADDER_OUT, UPD, BUSY
  );

  modport slave (
    input  REQ, NOTES, CONV_ADDER,
    output CONV_NOTE, ADDER_OUT, UPD, BUSY
  );
endinterface

// File: rtl/note2dds_voice_sched.sv
// Round-robin sharing of one note-to-DDS-increment converter across NUM_VOICES voices.
// Each service lasts CONV_LAT+2 cycles: issue, CONV_LAT wait cycles, capture.
//
// state   | meaning
// IDLE    | no service in flight; issues the next requesting voice to the converter
// WAIT    | converter settling, cnt counts down the remaining latency cycles
// CAPTURE | latch CONV_ADDER into the current voice's ADDER_OUT and strobe UPD
module note2dds_voice_sched #(
  parameter int NUM_VOICES = 4,
  parameter int CONV_LAT   = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  note2dds_voice_sched_if.slave   bus
);
  localparam int PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                state;
  logic [NUM_VOICES-1:0] pending;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         cur;
  logic [2:0]            cnt;

  logic [NUM_VOICES-1:0] cand;
  logic                  win_found;
  logic [PW-1:0]         win;
  logic [PW-1:0]         win_next;
  logic [NUM_VOICES-1:0] consume;

  // A request in the idle cycle itself is served without first passing through pending.
  assign cand = pending | bus.REQ;

  always_comb begin : pick
    logic [PW:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win       = rr_ptr;
    for (int i = 0; i < NUM_VOICES; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_VOICES)) idx = idx - (PW+1)'(NUM_VOICES);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win       = idx[PW-1:0];
      end
    end
  end

  assign win_next = (win == PW'(NUM_VOICES - 1)) ? '0 : win + 1'b1;
  assign consume  = (state == IDLE && win_found) ? (NUM_VOICES'(1) << win) : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      pending       <= '0;
      rr_ptr        <= '0;
      cur           <= '0;
      cnt           <= '0;
      bus.CONV_NOTE <= '0;
      bus.ADDER_OUT <= '0;
      bus.UPD       <= '0;
      bus.BUSY      <= 1'b0;
    end else begin
      // The issuing request is consumed only when it had not already been pending;
      // a REQ landing on the issue edge of an already pending voice re-arms it.
      pending <= (pending & ~consume) | (bus.REQ & ~(consume & ~pending));
      bus.UPD <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            bus.CONV_NOTE <= bus.NOTES[win*7 +: 7];
            cur           <= win;
            rr_ptr        <= win_next;
            cnt           <= 3'(CONV_LAT);
            state         <= WAIT;
            bus.BUSY      <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= CAPTURE;
        end
        CAPTURE: begin
          bus.ADDER_OUT[cur*32 +: 32] <= bus.CONV_ADDER;
          bus.UPD[cur]                <= 1'b1;
          bus.BUSY                    <= 1'b0;
          state                       <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.BUSY <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_note2dds_voice_sched.sv
// Directed bench for note2dds_voice_sched with a one-cycle-latency note-to-DDS converter model
// (fs = 100 MHz, A4 = 440 Hz, truncated increment).
module tb_note2dds_voice_sched;
  logic CLK = 1'b0;
  logic RESET;

  note2dds_voice_sched_if #(.NUM_VOICES(4)) bus ();

  note2dds_voice_sched #(.NUM_VOICES(4), .CONV_LAT(1)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int last_upd [4];
  int served   [4];
  logic [31:0] conv_stage = '0;

  function automatic logic [31:0] note2adder(input logic [6:0] n);
    real f;
    f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
    return 32'($rtoi(f * 42.94967296));
  endfunction

  // Converter model: CONV_ADDER follows CONV_NOTE one clock later.
  initial bus.CONV_ADDER = '0;
  always begin
    @(posedge CLK);
    #2;
    bus.CONV_ADDER = conv_stage;
    conv_stage     = note2adder(bus.CONV_NOTE);
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic set_note(input int v, input logic [6:0] n);
    bus.NOTES[v*7 +: 7] = n;
  endtask

  function automatic logic [31:0] adder(input int v);
    return bus.ADDER_OUT[v*32 +: 32];
  endfunction

  // REQ is driven for cycle 0 by the caller; this drops it and checks UPD for cycles 1..n.
  task automatic watch(input string tag, input int n,
                       input int ca, input int cb, input int cc, input int cd,
                       input logic [3:0] ua, input logic [3:0] ub,
                       input logic [3:0] uc, input logic [3:0] ud);
    logic [3:0] exp;
    for (int c = 1; c <= n; c++) begin
      cyc();
      if (c == 1) bus.REQ = '0;
      exp = (c == ca) ? ua : (c == cb) ? ub : (c == cc) ? uc : (c == cd) ? ud : 4'b0000;
      chk($sformatf("%s_upd_c%0d", tag, c), bus.UPD, exp);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    bus.REQ   = '0;
    bus.NOTES = '0;
    cyc();
    cyc();
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_upd", bus.UPD, 4'b0);
    chk("rst_conv_note", bus.CONV_NOTE, 7'd0);
    chk("rst_adder", bus.ADDER_OUT, 128'd0);
    RESET = 1'b0;
    cyc();

    // Contention and bit-exact values: all four voices at once from rr_ptr=0.
    set_note(0, 7'd0);
    set_note(1, 7'd60);
    set_note(2, 7'd127);
    set_note(3, 7'd69);
    bus.REQ = 4'b1111;
    chk("cont_busy_c0", bus.BUSY, 1'b0);
    watch("cont", 13, 3, 6, 9, 12, 4'b0001, 4'b0010, 4'b0100, 4'b1000);
    chk("val_note0", adder(0), 32'd351);
    chk("val_note60", adder(1), 32'd11236);
    chk("val_note127", adder(2), 32'd538754);
    chk("val_note69", adder(3), 32'd18897);

    // Single request on voice 1 with cycle-accurate timing.
    set_note(1, 7'd69);
    bus.REQ = 4'b0010;
    chk("single_busy_c0", bus.BUSY, 1'b0);
    cyc();
    bus.REQ = '0;
    chk("single_conv_note_c1", bus.CONV_NOTE, 7'd69);
    chk("single_busy_c1", bus.BUSY, 1'b1);
    chk("single_upd_c1", bus.UPD, 4'b0);
    cyc();
    chk("single_upd_c2", bus.UPD, 4'b0);
    chk("single_busy_c2", bus.BUSY, 1'b1);
    cyc();
    chk("single_upd_c3", bus.UPD, 4'b0010);
    chk("single_adder_c3", adder(1), 32'd18897);
    chk("single_busy_c3", bus.BUSY, 1'b0);
    chk("single_hold_v0", adder(0), 32'd351);
    for (int c = 4; c <= 6; c++) begin
      cyc();
      chk($sformatf("single_upd_c%0d", c), bus.UPD, 4'b0);
    end

    // Round-robin: serve voice 2, then voices 0 and 2 together -> 0 goes first.
    set_note(2, 7'd60);
    bus.REQ = 4'b0100;
    watch("rr_v2", 4, 3, -1, -1, -1, 4'b0100, 4'b0, 4'b0, 4'b0);
    chk("rr_v2_adder", adder(2), 32'd11236);
    set_note(0, 7'd127);
    set_note(2, 7'd0);
    bus.REQ = 4'b0101;
    watch("rr_pair", 7, 3, 6, -1, -1, 4'b0001, 4'b0100, 4'b0, 4'b0);
    chk("rr_adder_v0", adder(0), 32'd538754);
    chk("rr_adder_v2", adder(2), 32'd351);

    // Continuous requests on every voice: bounded wait, one-hot UPD.
    for (int v = 0; v < 4; v++) begin
      last_upd[v] = 0;
      served[v]   = 0;
    end
    bus.REQ = 4'b1111;
    for (int c = 1; c <= 48; c++) begin
      cyc();
      if (bus.UPD != 4'b0) begin
        chk($sformatf("starve_onehot_c%0d", c), $onehot(bus.UPD), 1'b1);
        for (int v = 0; v < 4; v++) begin
          if (bus.UPD[v]) begin
            chk($sformatf("starve_gap_v%0d_c%0d", v, c), (c - last_upd[v]) <= 12, 1'b1);
            last_upd[v] = c;
            served[v]++;
          end
        end
      end
    end
    bus.REQ = '0;
    for (int v = 0; v < 4; v++)
      chk($sformatf("starve_served_v%0d", v), served[v] >= 3, 1'b1);
    for (int c = 0; c < 16; c++) cyc();
    chk("starve_drained_busy", bus.BUSY, 1'b0);

    // Re-request on voice 3's own issue edge -> served twice, second with the newer note.
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    cyc();
    set_note(0, 7'd60);
    set_note(3, 7'd127);
    bus.REQ = 4'b1001;
    cyc();
    bus.REQ = '0;
    cyc();
    cyc();
    chk("rereq_upd_c3", bus.UPD, 4'b0001);
    chk("rereq_adder_v0", adder(0), 32'd11236);
    bus.REQ = 4'b1000;
    cyc();
    bus.REQ = '0;
    set_note(3, 7'd69);
    chk("rereq_conv_note_c4", bus.CONV_NOTE, 7'd127);
    cyc();
    chk("rereq_upd_c5", bus.UPD, 4'b0);
    cyc();
    chk("rereq_upd_c6", bus.UPD, 4'b1000);
    chk("rereq_adder_first", adder(3), 32'd538754);
    cyc();
    chk("rereq_conv_note_c7", bus.CONV_NOTE, 7'd69);
    cyc();
    cyc();
    chk("rereq_upd_c9", bus.UPD, 4'b1000);
    chk("rereq_adder_second", adder(3), 32'd18897);
    cyc();
    chk("rereq_upd_c10", bus.UPD, 4'b0);
    chk("rereq_busy_c10", bus.BUSY, 1'b0);

    // Reset in the middle of a WAIT aborts the service.
    set_note(1, 7'd69);
    bus.REQ = 4'b0010;
    cyc();
    bus.REQ = '0;
    chk("midrst_busy_before", bus.BUSY, 1'b1);
    RESET = 1'b1;
    #1;
    chk("midrst_busy", bus.BUSY, 1'b0);
    chk("midrst_upd", bus.UPD, 4'b0);
    chk("midrst_conv_note", bus.CONV_NOTE, 7'd0);
    chk("midrst_adder", bus.ADDER_OUT, 128'd0);
    cyc();
    RESET = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk($sformatf("midrst_after_upd_%0d", c), bus.UPD, 4'b0);
      chk($sformatf("midrst_after_busy_%0d", c), bus.BUSY, 1'b0);
    end
    chk("midrst_after_adder", bus.ADDER_OUT, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
